// File: rtl/prml_encoder_if.sv
// Handshake and channel-side signal bundle for the PRML transmit encoder.
interface prml_encoder_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             data_in;
  logic             data_valid;
  logic             data_ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             underrun;

  modport master (
    output start, frame_len, data_in, data_valid,
    input  data_ready, out, out_valid, busy, done, underrun
  );

  modport slave (
    input  start, frame_len, data_in, data_valid,
    output data_ready, out, out_valid, busy, done, underrun
  );
endinterface

// File: rtl/prml_encoder.sv
// PRML transmit encoder: a preamble followed by frame_len payload bits.
// Each bit becomes a channel pair (c1, c2), sent serially one bit per clock.
module prml_encoder #(
  parameter int PREAMBLE_PAIRS = 4,
  parameter int LEN_W          = 8
) (
  input logic           clock,
  input logic           reset,
  prml_encoder_if.slave bus
);
  localparam int PW = (PREAMBLE_PAIRS > 1) ? $clog2(PREAMBLE_PAIRS) : 1;

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t           r_state;
  logic             r_phase;
  logic             r_p1;
  logic             r_p2;
  logic [PW-1:0]    r_pre_idx;
  logic [LEN_W-1:0] r_rem;
  logic             r_out;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_underrun;
  logic             r_data_ready;

  logic             w_pre_last;
  logic             w_next_payload;
  logic             w_c2;
  logic             w_d;

  // Decode the next pair type and the second bit of the current pair.
  always_comb begin
    w_pre_last     = (r_pre_idx == PW'(PREAMBLE_PAIRS - 1));
    w_next_payload = (r_state == PRE) ? (w_pre_last && (r_rem != '0))
                                      : (r_rem != '0);
    w_c2           = r_p1 ? ~r_out : r_out;
    w_d            = bus.data_valid ? bus.data_in : 1'b0;
  end

  // Frame sequencer and serial pair encoder; every output is registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_phase      <= 1'b0;
      r_p1         <= 1'b0;
      r_p2         <= 1'b0;
      r_pre_idx    <= '0;
      r_rem        <= '0;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_data_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_rem       <= bus.frame_len;
            r_p1        <= 1'b0;
            r_p2        <= 1'b0;
            r_underrun  <= 1'b0;
            r_busy      <= 1'b1;
            // pair state is 00 and preamble bit 0 is 1, so c1 = 0 ^ 1
            r_out       <= 1'b1;
            r_out_valid <= 1'b1;
            r_phase     <= 1'b0;
            r_pre_idx   <= '0;
            r_state     <= PRE;
          end
        end
        PRE, DATA: begin
          if (!r_phase) begin
            r_out        <= w_c2;
            r_p1         <= r_out;
            r_p2         <= w_c2;
            r_phase      <= 1'b1;
            // ready is registered one cycle early so it lines up with the phase-1 cycle
            r_data_ready <= w_next_payload;
          end else if (r_data_ready) begin
            r_out   <= r_p2 ^ w_d;
            r_phase <= 1'b0;
            r_rem   <= r_rem - 1'b1;
            r_state <= DATA;
            if (!bus.data_valid) r_underrun <= 1'b1;
          end else if ((r_state == PRE) && !w_pre_last) begin
            // preamble data bit at index i is ~i[0]; next index gives r_pre_idx[0]
            r_pre_idx <= r_pre_idx + 1'b1;
            r_out     <= r_p2 ^ r_pre_idx[0];
            r_phase   <= 1'b0;
          end else begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_phase     <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out        = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.underrun   = r_underrun;
  assign bus.data_ready = r_data_ready;
endmodule

// File: tb/tb_prml_encoder.sv
// Directed bench for prml_encoder with PREAMBLE_PAIRS=4, LEN_W=8.
module tb_prml_encoder;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  prml_encoder_if #(.LEN_W(8)) bus ();

  prml_encoder #(.PREAMBLE_PAIRS(4), .LEN_W(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start a frame and follow it until done; records emitted bits and handshakes.
  task automatic frame(input logic [7:0] len, input logic [15:0] dat, input logic [15:0] val,
                       input int restart_at, input bit hold,
                       output logic [31:0] bits, output int nbits, output int nready,
                       output int done_at);
    int k;
    k = 0; bits = '0; nbits = 0; nready = 0; done_at = 0;
    bus.start = 1'b1;
    bus.frame_len = len;
    tick();
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (bus.out_valid) begin
        bits = {bits[30:0], bus.out};
        nbits++;
      end
      if (bus.done) begin
        done_at = c;
        break;
      end
      if (bus.data_ready) begin
        nready++;
        bus.data_in    = dat[k];
        bus.data_valid = val[k];
        k++;
      end else begin
        bus.data_in    = 1'($urandom);
        bus.data_valid = 1'($urandom);
      end
      if (c == restart_at) begin
        bus.start     = 1'b1;
        bus.frame_len = len + 8'd5;
      end else if (!hold) begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.data_valid = 1'b0;
  endtask

  logic [31:0] bits;
  int          nbits;
  int          nready;
  int          done_at;
  int          got;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.frame_len = '0; bus.data_in = 1'b0; bus.data_valid = 1'b0;
    tick(); tick();
    chk("reset_outputs", {26'd0, bus.out, bus.out_valid, bus.busy, bus.done, bus.underrun, bus.data_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: two payload bits of 1, always valid
    frame(8'd2, 16'h0003, 16'h0003, 0, 1'b0, bits, nbits, nready, done_at);
    chk("t1_bits", bits, 32'b1110_1001_0011);
    chk("t1_nbits", nbits, 32'd12);
    chk("t1_done_at", done_at, 32'd13);
    chk("t1_nready", nready, 32'd2);
    chk("t1_done_cycle", {29'd0, bus.busy, bus.out_valid, bus.out}, 32'd0);
    chk("t1_underrun", bus.underrun, 1'b0);
    tick();
    chk("t1_done_pulse_1cyc", bus.done, 1'b0);

    // 2: empty payload, preamble only
    frame(8'd0, 16'h0000, 16'h0000, 0, 1'b0, bits, nbits, nready, done_at);
    chk("t2_bits", bits, 32'b1110_1001);
    chk("t2_nbits", nbits, 32'd8);
    chk("t2_nready", nready, 32'd0);
    chk("t2_done_at", done_at, 32'd9);
    tick();

    // 3: second payload slot starved -> 0 inserted, sticky underrun
    frame(8'd2, 16'h0001, 16'h0001, 0, 1'b0, bits, nbits, nready, done_at);
    chk("t3_bits", bits, 32'b1110_1001_0000);
    chk("t3_done_at", done_at, 32'd13);
    chk("t3_underrun", bus.underrun, 1'b1);
    repeat (4) tick();
    chk("t3_underrun_sticky", bus.underrun, 1'b1);

    // 4: start re-pulsed mid-preamble with a different frame_len
    frame(8'd1, 16'h0000, 16'h0001, 3, 1'b0, bits, nbits, nready, done_at);
    chk("t4_bits", bits, 32'b1110_1001_11);
    chk("t4_nbits", nbits, 32'd10);
    chk("t4_done_at", done_at, 32'd11);
    chk("t4_underrun_cleared", bus.underrun, 1'b0);
    tick();

    // 5: reset during DATA, then a fresh one-bit frame
    bus.start = 1'b1; bus.frame_len = 8'd3;
    tick();
    bus.start = 1'b0; bus.data_in = 1'b1; bus.data_valid = 1'b1;
    repeat (10) tick();
    chk("t5_pre_reset_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_reset_async", {26'd0, bus.out, bus.out_valid, bus.busy, bus.done, bus.underrun, bus.data_ready}, 32'd0);
    tick();
    rst = 1'b0;
    bus.data_valid = 1'b0;
    got = 0;
    repeat (4) begin
      tick();
      if (bus.done || bus.busy) got++;
    end
    chk("t5_no_done_after_reset", got, 32'd0);
    frame(8'd1, 16'h0000, 16'h0001, 0, 1'b0, bits, nbits, nready, done_at);
    chk("t5_bits", bits, 32'b1110_1001_11);
    chk("t5_done_at", done_at, 32'd11);
    tick();

    // 6: start held high through done -> back-to-back frame
    frame(8'd0, 16'h0000, 16'h0000, 0, 1'b1, bits, nbits, nready, done_at);
    chk("t6_done_at", done_at, 32'd9);
    chk("t6_done_busy", bus.busy, 1'b0);
    tick();
    bus.start = 1'b0;
    chk("t6_next_first", {30'd0, bus.out_valid, bus.out}, 32'd3);
    chk("t6_next_busy", bus.busy, 1'b1);
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin
        got = c;
        break;
      end
      tick();
    end
    chk("t6_second_done", got, 32'd8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
